// File: rtl/pipe_flush_ctrl.sv
// pipe_flush_ctrl
//   Fetch/decode boundary sequencer for the RV32I pipeline. Decides each cycle
//   whether decode sees the fetched instruction or a NOP, whether the PC holds,
//   and which source feeds the next PC. Covers post-reset bubbles, branch/jump
//   redirects, trap entry, mret, and instruction-memory wait states.
//
//   Parameters
//     FLUSH_CYCLES  extra NOP cycles after the redirect cycle (>=1)
//     BOOT_FLUSH    NOP + PC-hold cycles after reset release (>=1)
//
//   Ports
//     clk_in           rising-edge clock
//     rst_in           synchronous reset, active-high
//     imem_ready_in    instruction memory returns a valid instruction this cycle
//     branch_taken_in  EX resolved a taken branch/jump (1-cycle)
//     trap_req_in      trap/interrupt request, held until trap_ack_o
//     mret_in          mret in EX (1-cycle)
//     flush_o          1 = decode mux substitutes a NOP
//     pc_stall_o       1 = PC register holds
//     pc_sel_o         00 PC+4, 01 branch target, 10 trap vector, 11 mepc
//     trap_ack_o       1-cycle pulse on the cycle a trap is accepted
//     state_o          debug: 0 BOOT, 1 RUN, 2 REDIRECT, 3 WAIT_MEM
//
//   Handshake: trap_req_in/trap_ack_o is a level request with a pulse
//   acknowledge; the request is taken on any cycle where trap_req_in=1 and the
//   controller is in RUN, REDIRECT or WAIT_MEM, and trap_ack_o=1 that same
//   cycle. In BOOT the request simply stays pending.
//
//   Outputs are combinational from the registered state and the current inputs,
//   because the redirect event must steer the PC in the same cycle it is seen.
module pipe_flush_ctrl #(
  parameter int FLUSH_CYCLES = 1,
  parameter int BOOT_FLUSH   = 2
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic       imem_ready_in,
  input  logic       branch_taken_in,
  input  logic       trap_req_in,
  input  logic       mret_in,
  output logic       flush_o,
  output logic       pc_stall_o,
  output logic [1:0] pc_sel_o,
  output logic       trap_ack_o,
  output logic [1:0] state_o
);

  localparam int MAX_CNT = (FLUSH_CYCLES > BOOT_FLUSH) ? FLUSH_CYCLES : BOOT_FLUSH;
  localparam int CW      = $clog2(MAX_CNT + 1);

  localparam logic [1:0] SEL_PC4  = 2'b00;
  localparam logic [1:0] SEL_BR   = 2'b01;
  localparam logic [1:0] SEL_TRAP = 2'b10;
  localparam logic [1:0] SEL_MEPC = 2'b11;

  typedef enum logic [1:0] {
    BOOT     = 2'd0,
    RUN      = 2'd1,
    REDIRECT = 2'd2,
    WAIT_MEM = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] cnt_dec;
  logic          cnt_last;

  // Event candidates. In REDIRECT only traps count: branch/mret there come
  // from instructions that are being squashed.
  logic ev_trap, ev_mret, ev_br, ev_any;

  always_comb begin
    cnt_dec  = (cnt_q != '0) ? (cnt_q - 1'b1) : '0;  // saturate at zero
    cnt_last = (cnt_q <= CW'(1));

    ev_trap = 1'b0;
    ev_mret = 1'b0;
    ev_br   = 1'b0;
    if (state_q != BOOT) begin
      ev_trap = trap_req_in;
      if (state_q != REDIRECT) begin
        ev_mret = mret_in & ~trap_req_in;
        ev_br   = branch_taken_in & ~trap_req_in & ~mret_in;
      end
    end
    ev_any = ev_trap | ev_mret | ev_br;
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    flush_o    = 1'b0;
    pc_stall_o = 1'b0;
    pc_sel_o   = SEL_PC4;
    trap_ack_o = 1'b0;

    if (ev_any) begin
      // Redirect cycle: steer the PC, bubble the wrong-path instruction.
      flush_o    = 1'b1;
      trap_ack_o = ev_trap;
      pc_sel_o   = ev_trap ? SEL_TRAP : (ev_mret ? SEL_MEPC : SEL_BR);
      state_d    = REDIRECT;
      cnt_d      = CW'(FLUSH_CYCLES);
    end else begin
      unique case (state_q)
        BOOT: begin
          flush_o    = 1'b1;
          pc_stall_o = 1'b1;
          cnt_d      = cnt_dec;
          if (cnt_last) state_d = RUN;
        end
        REDIRECT: begin
          flush_o = 1'b1;
          cnt_d   = cnt_dec;
          if (cnt_last) state_d = RUN;
        end
        RUN: begin
          if (!imem_ready_in) begin
            flush_o    = 1'b1;
            pc_stall_o = 1'b1;
            state_d    = WAIT_MEM;
          end
        end
        WAIT_MEM: begin
          // Ready returning passes the instruction through this same cycle.
          if (!imem_ready_in) begin
            flush_o    = 1'b1;
            pc_stall_o = 1'b1;
          end else begin
            state_d = RUN;
          end
        end
        default: state_d = BOOT;
      endcase
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= BOOT;
      cnt_q   <= CW'(BOOT_FLUSH);
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign state_o = state_q;

endmodule
